time_display_scan: RTL
======================

// Module: time_display_scan
// PURPOSE
//  Reader side of the time-set path: takes the binary minute (0-59) and hour (0-23) registers written by
//  the button-driven setter and drives the board's 4-digit multiplexed 7-segment display.
//  Iterative binary->BCD conversion, digit scanning, set-mode blanking blink, colon blink on DP.
//  Sits between the timekeeping/set logic and the board display pins; outputs are active-low.
// PARAMETERS
//  SCAN_DIV   16'd50000      clock cycles each digit stays enabled (one frame = 4*SCAN_DIV)
//  BLINK_DIV  25'd25000000   clock cycles per blink phase (toggle period of blink_phase)
// PORTS
//  clock        in   1   system clock; all state on posedge
//  reset_n      in   1   asynchronous, active-low reset
//  minutes      in   8   binary minutes, legal 0..59
//  hours        in   7   binary hours, legal 0..23
//  set_mode     in   1   1 = time being set; digits blink
//  an           out  4   digit enables, active-low; an[0]=min ones, an[1]=min tens, an[2]=hr ones, an[3]=hr tens
//  seg          out  7   segments {g,f,e,d,c,b,a}, active-low
//  dp           out  1   decimal point, active-low; used as colon on digit 2 only
// BEHAVIOUR
//  Reset (async, reset_n=0): an=4'b1111, seg=7'h7F, dp=1, scan/blink counters=0, digit index=0,
//   blink_phase=0, BCD regs=0, converter IDLE. Outputs leave reset state on first clock after release.
//  Scan: scan_cnt counts 0..SCAN_DIV-1; on wrap, digit index increments mod 4. an/seg/dp registered,
//   change one cycle after index update; exactly one an bit low at any time out of reset.
//  Snapshot: when digit index wraps 3->0, minutes/hours sampled into snap regs; converter started.
//   Inputs changing mid-frame do not affect current frame.
//  Converter FSM: IDLE -> MIN (subtract 10 from min work reg, tens++ while >=10, one step/cycle)
//   -> HR (same for hours) -> DONE (copy 4 BCD digits to display regs in one cycle) -> IDLE.
//   Worst case 5+2+2 = 9 cycles; display regs update atomically, never show a half-converted value.
//   Start arriving while not IDLE: ignored (cannot occur for SCAN_DIV>=16; SCAN_DIV<16 unsupported).
//  Range check: minutes>=60 -> both minute digits show dash (seg g only); hours>=24 -> both hour digits
//   dash. Checked on snapshot; converter still runs but result discarded for that pair.
//  Blink: blink_cnt counts 0..BLINK_DIV-1; on wrap blink_phase toggles.
//   set_mode=1 and blink_phase=1 -> all segments and dp off (seg=7'h7F, dp=1); an still scans.
//   set_mode=0 -> digits always lit; dp low on digit 2 when blink_phase=0 (1 Hz colon at 50 MHz).
//   set_mode=1 -> dp always off.
//  Leading zeros shown (09:05 displays 0,9,0,5). Decode 0-9 standard; codes 10-15 unreachable -> blank.
//  Reset mid-frame or mid-conversion: all state to reset values immediately; next frame starts clean.
//  Widths: work regs 8 bits min / 7 bits hr; tens regs 3 bits min / 2 bits hr; no overflow possible in range.
// STRUCTURE
//  Shared include fpww_defs.vh: SEG_BLANK=7'h7F, SEG_DASH=7'h3F, 10-entry digit->segment constants,
//   MIN_LIMIT=60, HR_LIMIT=24 (also used by the time-set block).
//  One sub-module: bin2bcd_iter (start/busy/done, binary in, tens/ones out), instantiated twice
//   (minutes, hours) or once time-shared per FSM; the top owns scan, blink, snapshot and decode.
// TESTING
//  (bench uses SCAN_DIV=16, BLINK_DIV=64)
//  1 Reset: reset_n=0 mid-scan -> same cycle an=1111, seg=7F, dp=1; release -> an cycles 1110,1101,1011,0111 each 16 clks.
//  2 Normal: minutes=47, hours=13, set_mode=0 -> frame after snapshot shows 7,4,3,1 on an[0..3]; dp low on an[2] only in phase 0.
//  3 Boundaries: minutes=0,hours=0 -> 0,0,0,0; minutes=59,hours=23 -> 9,5,3,2; conversion done <=9 clks after wrap.
//  4 Out of range: minutes=60,hours=24 -> all four digits seg=SEG_DASH; minutes=61,hours=5 -> dash,dash,5,0.
//  5 Set mode: set_mode=1 -> seg=7F, dp=1 for 64 clks, digits for next 64, repeating; an keeps scanning.
//  6 Mid-frame change: minutes 12->34 while index=1 -> current frame unchanged, next frame shows 4,3.

Source files
------------

// File: rtl/time_display_scan_pkg.sv
// Shared constants and types for the time display reader: segment codes, range limits,
// converter sequencing states and the digit-to-segment decoder.
package time_display_scan_pkg;

    localparam logic [6:0] SEG_BLANK = 7'h7F;
    localparam logic [6:0] SEG_DASH  = 7'h3F;
    localparam logic [7:0] MIN_LIMIT = 8'd60;
    localparam logic [6:0] HR_LIMIT  = 7'd24;

    typedef enum logic [1:0] {
        CONV_IDLE,
        CONV_MIN,
        CONV_HR,
        CONV_DONE
    } conv_state_e;

    // Active-low {g,f,e,d,c,b,a}; codes 10-15 never reach here in normal operation.
    function automatic logic [6:0] seg_decode(input logic [3:0] digit);
        logic [6:0] seg;
        case (digit)
            4'd0:    seg = 7'h40;
            4'd1:    seg = 7'h79;
            4'd2:    seg = 7'h24;
            4'd3:    seg = 7'h30;
            4'd4:    seg = 7'h19;
            4'd5:    seg = 7'h12;
            4'd6:    seg = 7'h02;
            4'd7:    seg = 7'h78;
            4'd8:    seg = 7'h00;
            4'd9:    seg = 7'h10;
            default: seg = SEG_BLANK;
        endcase
        return seg;
    endfunction

endpackage

// File: rtl/time_display_scan_if.sv
// Time values in from the set logic and multiplexed display pins out; the display reader is the slave.
interface time_display_scan_if;

    logic [7:0] minutes;
    logic [6:0] hours;
    logic       set_mode;
    logic [3:0] an;
    logic [6:0] seg;
    logic       dp;

    modport master (
        output minutes, hours, set_mode,
        input  an, seg, dp
    );

    modport slave (
        input  minutes, hours, set_mode,
        output an, seg, dp
    );

endinterface

// File: rtl/time_display_scan_bin2bcd_iter.sv
// Iterative binary to two-digit BCD: one subtract-by-ten per cycle, done while the remainder is < 10.
module bin2bcd_iter (
    input  logic       clock,
    input  logic       reset_n,
    input  logic       start_i,
    input  logic [7:0] bin_i,
    output logic       busy_o,
    output logic       done_o,
    output logic [2:0] tens_o,
    output logic [3:0] ones_o
);

    logic [7:0] work_q, work_d;
    logic [2:0] tens_q, tens_d;
    logic       busy_q, busy_d;

    always_comb begin
        work_d = work_q;
        tens_d = tens_q;
        busy_d = busy_q;
        if (start_i) begin
            work_d = bin_i;
            tens_d = 3'd0;
            busy_d = 1'b1;
        end else if (busy_q) begin
            if (work_q >= 8'd10) begin
                work_d = work_q - 8'd10;
                tens_d = tens_q + 3'd1;
            end else begin
                busy_d = 1'b0;
            end
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            work_q <= 8'd0;
            tens_q <= 3'd0;
            busy_q <= 1'b0;
        end else begin
            work_q <= work_d;
            tens_q <= tens_d;
            busy_q <= busy_d;
        end
    end

    // Result stays valid after busy drops until the next start.
    assign done_o = busy_q && (work_q < 8'd10);
    assign busy_o = busy_q;
    assign tens_o = tens_q;
    assign ones_o = work_q[3:0];

endmodule

// File: rtl/time_display_scan.sv
// Drives a 4-digit multiplexed 7-segment display from binary minutes/hours, with a per-frame
// snapshot, time-shared BCD conversion, set-mode blanking blink and a blinking colon on digit 2.
module time_display_scan
    import time_display_scan_pkg::*;
#(
    parameter logic [15:0] SCAN_DIV  = 16'd50000,
    parameter logic [24:0] BLINK_DIV = 25'd25000000
) (
    input  logic                 clock,
    input  logic                 reset_n,
    time_display_scan_if.slave   disp
);

    logic [15:0] scan_cnt_q, scan_cnt_d;
    logic [1:0]  digit_idx_q, digit_idx_d;
    logic [24:0] blink_cnt_q, blink_cnt_d;
    logic        blink_phase_q, blink_phase_d;
    logic        scan_wrap, blink_wrap, frame_start;

    logic [6:0]  snap_hr_q;
    logic        min_bad_q, hr_bad_q;
    logic        min_bad_now, hr_bad_now;

    conv_state_e state_q, state_d;
    logic        conv_start, conv_busy, conv_done;
    logic [7:0]  conv_bin;
    logic [2:0]  conv_tens;
    logic [3:0]  conv_ones;
    logic        min_latch, disp_load;
    logic [2:0]  min_tens_q;
    logic [3:0]  min_ones_q;

    // Digit codes indexed like an[]: 0=min ones, 1=min tens, 2=hr ones, 3=hr tens.
    logic [3:0][3:0] disp_digits_q;
    logic [1:0]      disp_dash_q;

    logic [3:0] an_q, an_d;
    logic [6:0] seg_q, seg_d;
    logic       dp_q, dp_d;
    logic       cur_dash;

    assign scan_wrap   = (scan_cnt_q == SCAN_DIV - 16'd1);
    assign blink_wrap  = (blink_cnt_q == BLINK_DIV - 25'd1);
    assign frame_start = scan_wrap && (digit_idx_q == 2'd3);
    assign min_bad_now = (disp.minutes >= MIN_LIMIT);
    assign hr_bad_now  = (disp.hours >= HR_LIMIT);

    always_comb begin
        scan_cnt_d    = scan_wrap ? 16'd0 : scan_cnt_q + 16'd1;
        digit_idx_d   = scan_wrap ? digit_idx_q + 2'd1 : digit_idx_q;
        blink_cnt_d   = blink_wrap ? 25'd0 : blink_cnt_q + 25'd1;
        blink_phase_d = blink_wrap ? ~blink_phase_q : blink_phase_q;
    end

    bin2bcd_iter u_conv (
        .clock   (clock),
        .reset_n (reset_n),
        .start_i (conv_start),
        .bin_i   (conv_bin),
        .busy_o  (conv_busy),
        .done_o  (conv_done),
        .tens_o  (conv_tens),
        .ones_o  (conv_ones)
    );

    // Out-of-range values convert as zero so the sequence stays short; their digits show dashes.
    always_comb begin
        state_d    = state_q;
        conv_start = 1'b0;
        conv_bin   = 8'd0;
        min_latch  = 1'b0;
        disp_load  = 1'b0;
        case (state_q)
            CONV_IDLE: begin
                if (frame_start && !conv_busy) begin
                    conv_start = 1'b1;
                    conv_bin   = min_bad_now ? 8'd0 : disp.minutes;
                    state_d    = CONV_MIN;
                end
            end
            CONV_MIN: begin
                if (conv_done) begin
                    min_latch  = 1'b1;
                    conv_start = 1'b1;
                    conv_bin   = hr_bad_q ? 8'd0 : {1'b0, snap_hr_q};
                    state_d    = CONV_HR;
                end
            end
            CONV_HR: begin
                if (conv_done) begin
                    state_d = CONV_DONE;
                end
            end
            CONV_DONE: begin
                disp_load = 1'b1;
                state_d   = CONV_IDLE;
            end
            default: state_d = CONV_IDLE;
        endcase
    end

    always_comb begin
        an_d              = 4'b1111;
        an_d[digit_idx_q] = 1'b0;
        cur_dash          = digit_idx_q[1] ? disp_dash_q[1] : disp_dash_q[0];
        seg_d             = cur_dash ? SEG_DASH : seg_decode(disp_digits_q[digit_idx_q]);
        if (disp.set_mode && blink_phase_q) begin
            seg_d = SEG_BLANK;
        end
        dp_d = ~(!disp.set_mode && !blink_phase_q && (digit_idx_q == 2'd2));
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            scan_cnt_q    <= 16'd0;
            digit_idx_q   <= 2'd0;
            blink_cnt_q   <= 25'd0;
            blink_phase_q <= 1'b0;
            snap_hr_q     <= 7'd0;
            min_bad_q     <= 1'b0;
            hr_bad_q      <= 1'b0;
            state_q       <= CONV_IDLE;
            min_tens_q    <= 3'd0;
            min_ones_q    <= 4'd0;
            disp_digits_q <= '0;
            disp_dash_q   <= 2'b00;
            an_q          <= 4'b1111;
            seg_q         <= SEG_BLANK;
            dp_q          <= 1'b1;
        end else begin
            scan_cnt_q    <= scan_cnt_d;
            digit_idx_q   <= digit_idx_d;
            blink_cnt_q   <= blink_cnt_d;
            blink_phase_q <= blink_phase_d;
            state_q       <= state_d;
            an_q          <= an_d;
            seg_q         <= seg_d;
            dp_q          <= dp_d;
            if (frame_start) begin
                snap_hr_q <= disp.hours;
                min_bad_q <= min_bad_now;
                hr_bad_q  <= hr_bad_now;
            end
            if (min_latch) begin
                min_tens_q <= conv_tens;
                min_ones_q <= conv_ones;
            end
            if (disp_load) begin
                disp_digits_q <= {{1'b0, conv_tens}, conv_ones, {1'b0, min_tens_q}, min_ones_q};
                disp_dash_q   <= {hr_bad_q, min_bad_q};
            end
        end
    end

    assign disp.an  = an_q;
    assign disp.seg = seg_q;
    assign disp.dp  = dp_q;

endmodule
